fifo_frame_serializer: RTL
==========================

Name: fifo_frame_serializer

Overview:
- Consumer side of the 8-bit single-clock FIFO.
- Pulls a frame of bytes out of the FIFO, serializes each byte MSB-first to the backscatter encoder over a valid/ready bit interface, and optionally appends the Gen2 CRC-16.
- Sits between the FIFO and the FM0/Miller encoder in the tag transmit path.

Parameters:
APPEND_CRC, 1, 1 = append the ones'-complement CRC-16 (16 bits, MSB first) after the payload; 0 = payload only
LEN_WIDTH, 8, width of frame_len; frame length in bytes, range 0..2^LEN_WIDTH-1
UNDERRUN_TIMEOUT, 255, consecutive cycles FETCH may see fifo_empty=1 before the frame aborts; must be >=1

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
tx_start  input  1  one-cycle request to start a frame; sampled in IDLE only
frame_len  input  LEN_WIDTH  payload byte count, latched with tx_start
fifo_empty  input  1  FIFO empty flag
fifo_read_en  output  1  FIFO read strobe
fifo_data  input  8  FIFO read data; valid while fifo_read_en=1
bit_out  output  1  serial bit to encoder
bit_valid  output  1  bit_out is valid
bit_ready  input  1  encoder accepts bit_out this cycle
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse at end of frame, normal or aborted
error  output  1  one-cycle pulse coincident with done on an underrun abort

Behaviour:
- Clock is clock; reset is reset_n, asynchronous active-low.
- Reset values, all outputs 0:
  - state=IDLE, shift register=0, crc=16'hFFFF, counters=0.
  - Reset mid-frame abandons the frame immediately; there is no done pulse.
- States: IDLE, FETCH, SHIFT, CRC, DONE.
- IDLE:
  - On tx_start=1, latch frame_len into bytes_left, preset crc=16'hFFFF and clear the timeout counter.
  - Next state is FETCH if frame_len!=0. If frame_len==0: CRC when APPEND_CRC=1, else DONE.
- tx_start is ignored in every state other than IDLE.
- FETCH:
  - fifo_read_en = (state==FETCH) & ~fifo_empty. This is combinational and asserted for exactly one cycle per byte.
  - fifo_data is captured into the shift register on the same rising edge. bit_cnt is set to 7 and the next state is SHIFT.
  - Each cycle with fifo_empty=1 increments the timeout counter. When the counter reaches UNDERRUN_TIMEOUT the block goes to DONE with an abort flag set.
  - The timeout counter clears on every successful fetch.
- SHIFT:
  - bit_out = shreg[7] and bit_valid=1, both registered.
  - A transfer happens when bit_valid & bit_ready; otherwise bit_out is held stable.
  - On each transfer: shift left by 1, update crc with the transferred bit, then decrement bit_cnt.
  - On the transfer with bit_cnt==0, bytes_left is decremented. Next state is FETCH if bytes_left>1, otherwise CRC when APPEND_CRC=1, otherwise DONE.
- CRC update (CRC-16/CCITT, poly 0x1021), for bit b:
  - fb = crc[15]^b
  - crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0)
- CRC state:
  - On entry, crc is replaced by ~crc and a 16-bit counter starts.
  - bit_out = crc[15] and bit_valid=1, with the same handshake as SHIFT.
  - Each transfer shifts crc left with no feedback.
  - After 16 transfers the next state is DONE.
- DONE:
  - done=1 for one cycle. error=1 in the same cycle only if entered by underrun.
  - bit_valid=0 and fifo_read_en=0. Next state is IDLE.
- No bubble between bytes other than one FETCH cycle (minimum). Back-to-back bits within a byte or the CRC have zero bubbles when bit_ready=1.
- Latency: tx_start at edge N gives FETCH at N+1 and the first bit_valid at N+2 when the FIFO is non-empty.

Test Plan:
- APPEND_CRC=0, FIFO holds 0xA5,0x3C, tx_start with frame_len=2, bit_ready=1:
  - bit stream is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - exactly two fifo_read_en pulses.
  - done one cycle after the last transfer; error=0.
- APPEND_CRC=1, FIFO holds 0x31..0x39 (ASCII "123456789"), frame_len=9:
  - 72 payload bits, then trailing 16 bits = 0xD64E, MSB first.
  - a receiver running the CRC over all 88 bits ends with residue 0x1D0F.
- Backpressure, frame 0xA5: drive bit_ready low for 5 cycles at bit 3:
  - bit_out holds 0 and bit_valid holds 1 throughout.
  - the stream is unchanged and no bit is duplicated or dropped.
- Underrun: frame_len=3, one byte in FIFO, UNDERRUN_TIMEOUT=4:
  - 8 bits are sent, then fifo_read_en stays 0.
  - done=1 and error=1 together 4 cycles after entering FETCH; busy returns to 0.
- frame_len=0 with APPEND_CRC=1:
  - no fifo_read_en.
  - 16 bits = ~0xFFFF = 0x0000 are sent, then done.
- Reset mid-frame: assert reset_n=0 during bit 5 of byte 1:
  - all outputs go to 0 asynchronously with no done pulse.
  - a subsequent tx_start runs a clean frame.

Source files
------------

// File: rtl/fifo_frame_serializer_if.sv
// FIFO-read and serial-bit handshake bundle between the frame serializer
// and its neighbours (FIFO on one side, FM0/Miller encoder on the other).
interface fifo_frame_serializer_if #(
  parameter int LEN_WIDTH = 8
);
  logic                 tx_start;
  logic [LEN_WIDTH-1:0] frame_len;
  logic                 fifo_empty;
  logic                 fifo_read_en;
  logic [7:0]           fifo_data;
  logic                 bit_out;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    input  tx_start, frame_len, fifo_empty, fifo_data, bit_ready,
    output fifo_read_en, bit_out, bit_valid, busy, done, error
  );

  modport slave (
    output tx_start, frame_len, fifo_empty, fifo_data, bit_ready,
    input  fifo_read_en, bit_out, bit_valid, busy, done, error
  );
endinterface

// File: rtl/fifo_frame_serializer.sv
// Pulls a frame of bytes from the tx FIFO and serializes it MSB-first to the
// backscatter encoder, optionally followed by the complemented Gen2 CRC-16.
//
// state | meaning
// IDLE  | waiting for tx_start
// FETCH | reading the next payload byte; counts empty cycles for underrun
// SHIFT | presenting payload bits, one per accepted transfer
// CRC   | presenting the 16 complemented CRC bits
// DONE  | one-cycle done (and error on underrun) pulse
module fifo_frame_serializer #(
  parameter bit APPEND_CRC       = 1'b1,
  parameter int LEN_WIDTH        = 8,
  parameter int UNDERRUN_TIMEOUT = 255
) (
  input logic                     clock,
  input logic                     reset_n,
  fifo_frame_serializer_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] CRC   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int               TMO_W    = $clog2(UNDERRUN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(UNDERRUN_TIMEOUT - 1);

  logic [2:0]           state,      state_nx;
  logic [7:0]           shreg,      shreg_nx;
  logic [15:0]          crc,        crc_nx;
  logic [LEN_WIDTH-1:0] bytes_left, bytes_nx;
  logic [2:0]           bit_cnt,    bit_cnt_nx;
  logic [3:0]           crc_cnt,    crc_cnt_nx;
  logic [TMO_W-1:0]     tmo_cnt,    tmo_nx;
  logic                 abort,      abort_nx;
  logic                 bit_out_q,  bit_out_nx;
  logic                 bit_valid_q, bit_valid_nx;
  logic [15:0]          crc_upd;
  logic                 xfer;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign xfer    = bit_valid_q & bus.bit_ready;
  assign crc_upd = crc_step(crc, shreg[7]);

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    crc_nx     = crc;
    bytes_nx   = bytes_left;
    bit_cnt_nx = bit_cnt;
    crc_cnt_nx = crc_cnt;
    tmo_nx     = tmo_cnt;
    abort_nx   = abort;
    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          bytes_nx = bus.frame_len;
          crc_nx   = 16'hFFFF;
          tmo_nx   = '0;
          abort_nx = 1'b0;
          if (bus.frame_len != '0) begin
            state_nx = FETCH;
          end else if (APPEND_CRC) begin
            // empty payload: the complemented preset is sent straight away
            state_nx   = CRC;
            crc_nx     = ~16'hFFFF;
            crc_cnt_nx = 4'd15;
          end else begin
            state_nx = DONE;
          end
        end
      end
      FETCH: begin
        if (!bus.fifo_empty) begin
          shreg_nx   = bus.fifo_data;
          bit_cnt_nx = 3'd7;
          tmo_nx     = '0;
          state_nx   = SHIFT;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_nx   = tmo_cnt + TMO_W'(1);
          abort_nx = 1'b1;
          state_nx = DONE;
        end else begin
          tmo_nx = tmo_cnt + TMO_W'(1);
        end
      end
      SHIFT: begin
        if (xfer) begin
          shreg_nx   = {shreg[6:0], 1'b0};
          crc_nx     = crc_upd;
          bit_cnt_nx = bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            bytes_nx = bytes_left - LEN_WIDTH'(1);
            if (bytes_left > LEN_WIDTH'(1)) begin
              state_nx = FETCH;
            end else if (APPEND_CRC) begin
              state_nx   = CRC;
              crc_nx     = ~crc_upd;
              crc_cnt_nx = 4'd15;
            end else begin
              state_nx = DONE;
            end
          end
        end
      end
      CRC: begin
        if (xfer) begin
          crc_nx     = {crc[14:0], 1'b0};
          crc_cnt_nx = crc_cnt - 4'd1;
          if (crc_cnt == 4'd0) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // bit_out/bit_valid are registered from the next-state view so the encoder
  // sees a clean flop output with no combinational path from bit_ready.
  always_comb begin
    bit_out_nx   = 1'b0;
    bit_valid_nx = 1'b0;
    if (state_nx == SHIFT) begin
      bit_out_nx   = shreg_nx[7];
      bit_valid_nx = 1'b1;
    end else if (state_nx == CRC) begin
      bit_out_nx   = crc_nx[15];
      bit_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      crc         <= 16'hFFFF;
      bytes_left  <= '0;
      bit_cnt     <= '0;
      crc_cnt     <= '0;
      tmo_cnt     <= '0;
      abort       <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      shreg       <= shreg_nx;
      crc         <= crc_nx;
      bytes_left  <= bytes_nx;
      bit_cnt     <= bit_cnt_nx;
      crc_cnt     <= crc_cnt_nx;
      tmo_cnt     <= tmo_nx;
      abort       <= abort_nx;
      bit_out_q   <= bit_out_nx;
      bit_valid_q <= bit_valid_nx;
    end
  end

  assign bus.fifo_read_en = (state == FETCH) & ~bus.fifo_empty;
  assign bus.bit_out      = bit_out_q;
  assign bus.bit_valid    = bit_valid_q;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.error        = (state == DONE) & abort;

endmodule
